// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_arbiter
//  Description : Round-robin arbiter for a shared FIFO read port. It grants a
//                burst of reads to one requester and tags each word it delivers.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter #(
    parameter int dato_width = 8,
    parameter int N_REQ      = 2,
    parameter int BURST_MAX  = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [N_REQ-1:0]                        req,
    output logic [N_REQ-1:0]                        gnt,
    output logic                                    fifo_rd,
    input  logic                                    fifo_empy,
    input  logic [dato_width-1:0]                   fifo_datout,
    output logic [dato_width-1:0]                   dout,
    output logic                                    dout_valid,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] dout_id,
    output logic                                    burst_done
);

    localparam int c_idw = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_bw  = $clog2(BURST_MAX + 1);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_grant = 3'd1;
    localparam logic [2:0] c_rd    = 3'd2;
    localparam logic [2:0] c_cap   = 3'd3;
    localparam logic [2:0] c_rel   = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [c_idw-1:0] r_owner;
    logic [c_idw-1:0] w_owner;
    logic [c_idw-1:0] r_last;
    logic [c_bw-1:0]  r_beat;
    logic [c_bw-1:0]  w_beat_inc;
    logic [c_idw-1:0] w_win;
    logic [c_idw-1:0] w_idx;
    logic             w_found;
    logic             w_req_own;

    assign w_beat_inc = r_beat + c_bw'(1);
    assign w_req_own  = req[r_owner];

    // Scan starts just after the last served requester and wraps around.
    always_comb begin
        w_win   = r_last;
        w_idx   = r_last;
        w_found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = c_idw'((int'(r_last) + i) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_owner      = r_owner;
        case (r_state)
            c_idle: begin
                if (|req) begin
                    w_next_state = c_grant;
                    w_owner      = w_win;
                end
            end
            c_grant: begin
                if (!w_req_own) begin
                    w_next_state = c_rel;
                end else if (!fifo_empy) begin
                    w_next_state = c_rd;
                end
            end
            c_rd: w_next_state = c_cap;
            c_cap: begin
                if ((w_beat_inc == c_bw'(BURST_MAX)) || !w_req_own) begin
                    w_next_state = c_rel;
                end else begin
                    w_next_state = c_grant;
                end
            end
            c_rel:   w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with
    // the state it belongs to; gnt is therefore already low during REL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_owner    <= '0;
            r_last     <= c_idw'(N_REQ - 1);
            r_beat     <= '0;
            gnt        <= '0;
            fifo_rd    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_id    <= '0;
            burst_done <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_owner    <= w_owner;
            fifo_rd    <= (w_next_state == c_rd);
            burst_done <= (w_next_state == c_rel);
            dout_valid <= (r_state == c_cap);
            if ((w_next_state == c_grant) || (w_next_state == c_rd) || (w_next_state == c_cap)) begin
                gnt <= N_REQ'(1) << w_owner;
            end else begin
                gnt <= '0;
            end
            if (r_state == c_cap) begin
                dout    <= fifo_datout;
                dout_id <= r_owner;
                r_beat  <= w_beat_inc;
            end
            if (r_state == c_rel) begin
                r_last <= r_owner;
                r_beat <= '0;
            end
        end
    end

endmodule
`default_nettype wire
